// File: rtl/conv_feeder_pkg.sv
// Shared definitions for the convolution feeder: FSM state encoding and the
// word offsets of the bias and first activation inside a job's memory image.
package conv_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    STREAM = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5
  } feederState_e;

  // Weights occupy words 0..k*k-1, so the bias sits right after them.
  function automatic int biasOffset(input int k);
    return k * k;
  endfunction

  function automatic int actOffset(input int k);
    return k * k + 1;
  endfunction

endpackage

// File: rtl/conv_feeder.sv
// Convolution feeder: reads kernel weights, bias and a raster-order feature map
// from memory and streams the activations to a convolver, then flushes it.
module conv_feeder
  import conv_feeder_pkg::*;
#(
  parameter int dataWidth = 8,
  parameter int W         = 58,
  parameter int K         = 3,
  parameter int ADDR_W    = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic                       clk,
  input  logic                       global_rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       hold,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [dataWidth-1:0]       mem_rdata,
  output logic [K*K*dataWidth-1:0]   weight,
  output logic [dataWidth-1:0]       bias,
  output logic [dataWidth-1:0]       myInput,
  output logic                       ce,
  output logic                       busy,
  output logic                       done
);

  localparam int NUM_W   = biasOffset(K);
  localparam int NUM_ACT = W * W;
  localparam int CNT_W   = $clog2(NUM_ACT + NUM_W + FLUSH_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_W + 1);

  feederState_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic                     rdEn_q, rdEn_d;
  logic                     ce_q, ce_d;
  logic                     actValid_q, actValid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     loadPend_q, loadPend_d;
  logic [IDX_W-1:0]         loadIdx_q, loadIdx_d;
  logic [K*K*dataWidth-1:0] weight_q, weight_d;
  logic [dataWidth-1:0]     bias_q, bias_d;
  logic                     rdFire;

  // A pending read only issues if the convolver side is not stalling it this cycle.
  assign rdFire = rdEn_q & ~(hold & (state_q == STREAM));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    base_d     = base_q;
    rdEn_d     = 1'b0;
    ce_d       = 1'b0;
    actValid_d = 1'b0;
    done_d     = 1'b0;
    loadPend_d = 1'b0;
    loadIdx_d  = loadIdx_q;
    weight_d   = weight_q;
    bias_d     = bias_q;

    // Data for a load read returns one cycle after it was issued.
    if (loadPend_q) begin
      if (loadIdx_q == IDX_W'(NUM_W)) begin
        bias_d = mem_rdata;
      end
      for (int j = 0; j < NUM_W; j++) begin
        if (loadIdx_q == IDX_W'(j)) begin
          weight_d[j*dataWidth +: dataWidth] = mem_rdata;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          base_d  = base_addr;
          addr_d  = base_addr;
          rdEn_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        loadPend_d = 1'b1;
        loadIdx_d  = IDX_W'(cnt_q);
        rdEn_d     = 1'b1;
        addr_d     = addr_q + ADDR_W'(1);
        if (cnt_q == CNT_W'(NUM_W - 1)) begin
          state_d = LOAD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD_B: begin
        loadPend_d = 1'b1;
        loadIdx_d  = IDX_W'(NUM_W);
        rdEn_d     = 1'b1;
        addr_d     = base_q + ADDR_W'(actOffset(K));
        cnt_d      = '0;
        state_d    = STREAM;
      end
      STREAM: begin
        if (rdEn_q) begin
          rdEn_d = 1'b1;
          if (rdFire) begin
            addr_d     = addr_q + ADDR_W'(1);
            cnt_d      = cnt_q + CNT_W'(1);
            ce_d       = 1'b1;
            actValid_d = 1'b1;
            rdEn_d     = (cnt_q != CNT_W'(NUM_ACT - 1));
          end
        end else if (FLUSH_CYC > 0) begin
          // The last activation is on myInput this cycle; start flushing next.
          state_d = FLUSH;
          ce_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ce_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      rdEn_q     <= 1'b0;
      ce_q       <= 1'b0;
      actValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loadPend_q <= 1'b0;
      loadIdx_q  <= '0;
      weight_q   <= '0;
      bias_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      rdEn_q     <= rdEn_d;
      ce_q       <= ce_d;
      actValid_q <= actValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loadPend_q <= loadPend_d;
      loadIdx_q  <= loadIdx_d;
      weight_q   <= weight_d;
      bias_q     <= bias_d;
    end
  end

  // mem_rdata comes straight from the memory's output register, so the
  // activation path is only a gate that zeroes it outside activation cycles.
  assign mem_rd_en = rdFire;
  assign mem_addr  = addr_q;
  assign weight    = weight_q;
  assign bias      = bias_q;
  assign myInput   = actValid_q ? mem_rdata : '0;
  assign ce        = ce_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
